// File: rtl/base_fifo_sched_pkg.sv
// Shared definitions for the credit-based FIFO scheduler: packet-lock state
// encoding and an elaboration-time log2 helper for parameter checks.
package base_fifo_sched_pkg;

  // Packet lock: FREE lets the round-robin pick run, HELD pins the grant to
  // the way whose packet is mid-flight so beats are never interleaved.
  typedef enum logic {
    LOCK_FREE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  // Smallest r with 2**r >= value; used to sanity-check id/credit widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/base_fifo_sched_rr_pick.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ... modulo ways and
// returns the first requesting way as a one-hot grant plus its index.
module base_fifo_sched_rr_pick
  import base_fifo_sched_pkg::*;
#(
  parameter int ways     = 4,
  parameter int id_width = 2
) (
  input  logic [ways-1:0]     req,
  input  logic [id_width-1:0] ptr,
  output logic [ways-1:0]     gnt,
  output logic [id_width-1:0] gnt_id,
  output logic                any
);

  int idx;

  // First requester after the last-served way wins; ptr itself is searched last.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 1; i <= ways; i++) begin
      idx = (int'(ptr) + i) % ways;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = id_width'(idx);
      end
    end
  end

endmodule

// File: rtl/base_fifo_sched.sv
// Credit-based round-robin scheduler feeding one shared downstream FIFO.
// Each way may hold at most `credits` beats in the FIFO; packets are kept
// contiguous, and every output beat carries its source way for credit return.
module base_fifo_sched
  import base_fifo_sched_pkg::*;
#(
  parameter int ways     = 4,
  parameter int width    = 8,
  parameter int id_width = 2,
  parameter int credits  = 4,
  parameter int cr_width = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ways-1:0]       i_v,
  output logic [ways-1:0]       i_r,
  input  logic [ways*width-1:0] i_d,
  input  logic [ways-1:0]       i_e,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [width-1:0]      o_d,
  output logic                  o_e,
  output logic [id_width-1:0]   o_s,
  input  logic                  cr_v,
  input  logic [id_width-1:0]   cr_s,
  output logic                  err
);

  localparam logic [cr_width-1:0] CrMax   = cr_width'(credits);
  localparam logic [id_width-1:0] PtrInit = id_width'(ways - 1);

  if (clog2(ways) > id_width) begin : g_bad_id_width
    $error("base_fifo_sched: id_width too narrow for ways");
  end
  if (clog2(credits + 1) > cr_width) begin : g_bad_cr_width
    $error("base_fifo_sched: cr_width too narrow for credits");
  end

  lock_state_t           lock_q, lock_d;
  logic [id_width-1:0]   lock_way_q, lock_way_d;
  logic [id_width-1:0]   ptr_q, ptr_d;
  logic [id_width-1:0]   pick_id, g_id;
  logic [ways-1:0]       elig, ret, acc, grant, pick_gnt, cnt_ovf;
  logic                  pick_any, ld, acc_any, range_err;

  logic                  o_v_q, o_v_d;
  logic                  o_e_q, o_e_d;
  logic [width-1:0]      o_d_q, o_d_d;
  logic [id_width-1:0]   o_s_q, o_s_d;
  logic                  err_q, err_d;

  base_fifo_sched_rr_pick #(
    .ways     (ways),
    .id_width (id_width)
  ) u_pick (
    .req    (elig),
    .ptr    (ptr_q),
    .gnt    (pick_gnt),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // Grant: a held packet owns the output even if its way is idle or out of credit.
  always_comb begin
    grant   = pick_gnt;
    g_id    = pick_id;
    ld      = ~o_v_q | o_r;
    acc_any = ld & pick_any;
    if (lock_q == LOCK_HELD) begin
      grant             = '0;
      grant[lock_way_q] = 1'b1;
      g_id              = lock_way_q;
      acc_any           = ld & elig[lock_way_q];
    end
    acc = {ways{ld}} & grant & elig;
  end

  assign i_r = acc;

  // Per-way credit counters: accept spends a credit, a return refunds one.
  for (genvar k = 0; k < ways; k++) begin : g_way
    logic [cr_width-1:0] cnt_q, cnt_d;
    logic                ovf;

    assign elig[k]    = i_v[k] & (cnt_q != '0);
    assign ret[k]     = cr_v & (cr_s == id_width'(k));
    assign cnt_ovf[k] = ovf;

    // Simultaneous accept and return cancel; a refund past full is flagged.
    always_comb begin
      cnt_d = cnt_q;
      ovf   = 1'b0;
      if (acc[k] && !ret[k]) begin
        cnt_d = cnt_q - 1'b1;
      end else if (ret[k] && !acc[k]) begin
        if (cnt_q == CrMax) ovf   = 1'b1;
        else                cnt_d = cnt_q + 1'b1;
      end
    end

    // Credit register, full budget after reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= CrMax;
      else       cnt_q <= cnt_d;
    end
  end

  // Lock FSM next state: a non-final beat holds the output for its way.
  always_comb begin
    lock_d     = lock_q;
    lock_way_d = lock_way_q;
    ptr_d      = ptr_q;
    if (acc_any) begin
      ptr_d      = g_id;
      lock_way_d = g_id;
      lock_d     = i_e[g_id] ? LOCK_FREE : LOCK_HELD;
    end
  end

  // Lock FSM and round-robin pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q     <= LOCK_FREE;
      lock_way_q <= '0;
      ptr_q      <= PtrInit;
    end else begin
      lock_q     <= lock_d;
      lock_way_q <= lock_way_d;
      ptr_q      <= ptr_d;
    end
  end

  assign range_err = cr_v & (int'(cr_s) >= ways);

  // Output stage: load on accept, drop valid when consumed, otherwise hold.
  always_comb begin
    o_v_d = o_v_q;
    o_d_d = o_d_q;
    o_e_d = o_e_q;
    o_s_d = o_s_q;
    err_d = err_q | (|cnt_ovf) | range_err;
    if (acc_any) begin
      o_v_d = 1'b1;
      o_d_d = i_d[int'(g_id)*width +: width];
      o_e_d = i_e[g_id];
      o_s_d = g_id;
    end else if (o_v_q && o_r) begin
      o_v_d = 1'b0;
    end
  end

  // Output register and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_v_q <= 1'b0;
      o_d_q <= '0;
      o_e_q <= 1'b0;
      o_s_q <= '0;
      err_q <= 1'b0;
    end else begin
      o_v_q <= o_v_d;
      o_d_q <= o_d_d;
      o_e_q <= o_e_d;
      o_s_q <= o_s_d;
      err_q <= err_d;
    end
  end

  assign o_v = o_v_q;
  assign o_d = o_d_q;
  assign o_e = o_e_q;
  assign o_s = o_s_q;
  assign err = err_q;

endmodule

// File: tb/tb_base_fifo_sched.sv
// Directed bench for base_fifo_sched (ways=4, width=8, credits=4) with a
// cycle model of the scheduler and an output scoreboard.
module tb_base_fifo_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  i_v, i_r, i_e;
  logic [31:0] i_d;
  logic        o_v, o_r, o_e;
  logic [7:0]  o_d;
  logic [1:0]  o_s;
  logic        cr_v;
  logic [1:0]  cr_s;
  logic        err;

  always #5 clk = ~clk;

  base_fifo_sched #(
    .ways     (4),
    .width    (8),
    .id_width (2),
    .credits  (4),
    .cr_width (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .i_v   (i_v),
    .i_r   (i_r),
    .i_d   (i_d),
    .i_e   (i_e),
    .o_v   (o_v),
    .o_r   (o_r),
    .o_d   (o_d),
    .o_e   (o_e),
    .o_s   (o_s),
    .cr_v  (cr_v),
    .cr_s  (cr_s),
    .err   (err)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       e;
    logic [1:0] s;
  } beat_t;

  beat_t      sb[$];
  int         compared = 0;
  int         mismatched = 0;
  int         m_ptr, m_lw, popped, n, dv;
  int         m_cnt[4];
  bit         m_lock, m_ov, m_err, m_acc, m_pop, pend;
  logic [3:0] m_ir;
  logic [3:0] t1_ir[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] t1_os[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ptr  = 3;
    m_lw   = 0;
    m_lock = 1'b0;
    m_ov   = 1'b0;
    m_err  = 1'b0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 4;
    sb.delete();
  endtask

  // Sample on the falling edge, check against the model, then advance the
  // model to what the next rising edge should produce.
  task automatic neg();
    bit    ld, found, a, r;
    int    g, w;
    beat_t b;
    @(negedge clk);
    chk("o_v", o_v, m_ov);
    chk("err", err, m_err);
    m_pop = 1'b0;
    if (m_ov && sb.size() > 0) begin
      chk("o_d", o_d, sb[0].d);
      chk("o_e", o_e, sb[0].e);
      chk("o_s", o_s, sb[0].s);
      if (o_r) begin
        void'(sb.pop_front());
        popped++;
        m_pop = 1'b1;
      end
    end
    ld    = !m_ov || o_r;
    found = 1'b0;
    g     = 0;
    if (m_lock) begin
      found = 1'b1;
      g     = m_lw;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        w = (m_ptr + k) % 4;
        if (!found && i_v[w] && m_cnt[w] != 0) begin
          found = 1'b1;
          g     = w;
        end
      end
    end
    m_ir = '0;
    if (ld && found && i_v[g] && m_cnt[g] != 0) m_ir[g] = 1'b1;
    chk("i_r", i_r, m_ir);
    m_acc = (m_ir != 4'b0);
    if (m_acc) begin
      b.d = i_d[g*8 +: 8];
      b.e = i_e[g];
      b.s = 2'(g);
      sb.push_back(b);
      m_ov   = 1'b1;
      m_ptr  = g;
      m_lock = !i_e[g];
      m_lw   = g;
    end else if (m_ov && o_r) begin
      m_ov = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      a = m_ir[k];
      r = cr_v && (cr_s == 2'(k));
      if (a && !r) m_cnt[k]--;
      else if (r && !a) begin
        if (m_cnt[k] == 4) m_err = 1'b1;
        else               m_cnt[k]++;
      end
    end
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    neg();
    pos();
  endtask

  // Drain the output and hand back every outstanding credit.
  task automatic refill();
    i_v  = 4'b0;
    o_r  = 1'b1;
    cr_v = 1'b0;
    cyc();
    cyc();
    for (int k = 0; k < 4; k++) begin
      while (m_cnt[k] < 4) begin
        cr_v = 1'b1;
        cr_s = 2'(k);
        cyc();
      end
    end
    cr_v = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_v   = 4'b0;
    i_e   = 4'b0;
    i_d   = 32'h0;
    o_r   = 1'b1;
    cr_v  = 1'b0;
    cr_s  = 2'd0;
    pend  = 1'b0;
    popped = 0;
    m_reset();
    @(posedge clk);
    #1;
    chk("rst_o_v", o_v, 1'b0);
    chk("rst_o_d", o_d, 8'h00);
    chk("rst_o_e", o_e, 1'b0);
    chk("rst_o_s", o_s, 2'd0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;

    // Round-robin order from reset, way 0 first.
    i_v = 4'hF;
    i_e = 4'hF;
    i_d = 32'h33221100;
    for (int i = 0; i < 6; i++) begin
      neg();
      if (i < 5) chk("t1_ir", i_r, t1_ir[i]);
      if (i > 0) chk("t1_os", o_s, t1_os[i-1]);
      pos();
    end
    refill();

    // Way 1 three-beat packet stays contiguous, then way 2, then way 0.
    i_e = 4'b1101; i_d = 32'h22101100; i_v = 4'b0010;
    neg(); chk("t2_ir_a", i_r, 4'b0010); pos();
    i_v = 4'b0111; i_d[15:8] = 8'h11;
    neg(); chk("t2_ir_b", i_r, 4'b0010); chk("t2_os_b", o_s, 2'd1); pos();
    i_e = 4'b1111; i_d[15:8] = 8'h12;
    neg(); chk("t2_ir_c", i_r, 4'b0010); chk("t2_os_c", o_s, 2'd1); pos();
    i_v = 4'b0101;
    neg(); chk("t2_ir_d", i_r, 4'b0100); chk("t2_os_d", o_s, 2'd1); pos();
    i_v = 4'b0001;
    neg(); chk("t2_ir_e", i_r, 4'b0001); chk("t2_os_e", o_s, 2'd2); pos();
    i_v = 4'b0000;
    neg(); chk("t2_os_f", o_s, 2'd0); chk("t2_od_f", o_d, 8'h00); pos();
    refill();

    // Credit exhaustion on way 3, then a single refund buys one beat.
    i_v = 4'b1000; i_e = 4'hF; i_d = 32'hA3000000; n = 0;
    for (int c = 0; c < 6; c++) begin
      neg();
      if (i_r[3]) n++;
      if (c == 5) chk("t3_ir_dry", i_r, 4'b0000);
      pos();
    end
    chk("t3_accepts", n, 4);
    cr_v = 1'b1; cr_s = 2'd3;
    neg(); chk("t3_ir_ret", i_r, 4'b0000); pos();
    cr_v = 1'b0; n = 0;
    for (int c = 0; c < 4; c++) begin
      neg();
      if (i_r[3]) n++;
      pos();
    end
    chk("t3_one_more", n, 1);
    refill();

    // 256-beat stream on way 0 with a 5-cycle downstream stall.
    i_e = 4'hF; popped = 0; dv = 0; pend = 1'b0;
    for (int c = 0; c < 3000 && popped < 256; c++) begin
      cr_v = pend;
      cr_s = 2'd0;
      o_r  = !(c >= 100 && c < 105);
      i_v  = {3'b0, dv < 256};
      i_d  = {24'h0, 8'(dv)};
      neg();
      if (c >= 101 && c < 105) begin
        chk("t4_stall_ir", i_r, 4'b0000);
        chk("t4_stall_ov", o_v, 1'b1);
      end
      pend = m_pop;
      if (m_acc) dv++;
      pos();
    end
    chk("t4_popped", popped, 256);
    chk("t4_sb_empty", sb.size(), 0);
    cr_v = pend; i_v = 4'b0;
    cyc();
    refill();

    // Full-rate accept with same-cycle return on way 2, then an overflow.
    i_v = 4'b0100; i_e = 4'hF; i_d = 32'h00C20000; cr_v = 1'b1; cr_s = 2'd2;
    for (int c = 0; c < 10; c++) begin
      neg();
      chk("t5_ir_full", i_r, 4'b0100);
      pos();
    end
    i_v = 4'b0;
    neg(); chk("t5_err_pre", err, 1'b0); pos();
    cr_v = 1'b0;
    neg(); chk("t5_err_set", err, 1'b1); pos();
    cyc(); cyc();
    neg(); chk("t5_err_sticky", err, 1'b1); pos();

    // Async reset in the middle of a stalled way-0 packet.
    i_v = 4'b0001; i_e = 4'b0000; i_d = 32'h000000D0; o_r = 1'b0;
    cyc();
    cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("t6_o_v", o_v, 1'b0);
    chk("t6_err", err, 1'b0);
    chk("t6_o_d", o_d, 8'h00);
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    i_v = 4'hF; i_e = 4'hF; i_d = 32'h63524130; o_r = 1'b1; cr_v = 1'b0; n = 0;
    for (int c = 0; c < 20; c++) begin
      neg();
      if (c == 0) chk("t6_first", i_r, 4'b0001);
      n += $countones(i_r);
      pos();
    end
    chk("t6_total", n, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
